// File: rtl/rom_scan_sequencer.sv
// Reads all 64 bytes of the 8x8 coefficient ROM in raster or JPEG zigzag order
// and streams them on valid/ready with their scan index, absorbing backpressure.
module rom_scan_sequencer #(
    parameter int unsigned DW        = 8,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    output logic          busy,
    output logic          done,
    output logic [5:0]    rom_a,
    input  logic [DW-1:0] rom_d,
    output logic [DW-1:0] out_data,
    output logic [5:0]    out_index,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int unsigned CW    = 3;
    localparam int          DEPTH = int'(BUF_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state, state_nxt;
    logic          busy_nxt, done_nxt;
    logic          start_accept;

    logic          mode_q;
    logic [2:0]    row, col, row_nxt, col_nxt;
    logic [5:0]    issue_cnt, emit_cnt;
    logic          issue;
    logic          inflight;
    logic [5:0]    inflight_idx;

    logic [DW-1:0] buf_data [BUF_DEPTH];
    logic [5:0]    buf_idx  [BUF_DEPTH];
    logic [DW-1:0] data_nxt [BUF_DEPTH];
    logic [5:0]    idx_nxt  [BUF_DEPTH];
    logic [CW-1:0] buf_cnt, cnt_nxt, wr_ptr;
    logic          push, pop;

    assign rom_a     = {row, col};
    assign out_data  = buf_data[0];
    assign out_index = buf_idx[0];
    assign pop       = out_valid && out_ready;
    assign push      = inflight;

    // Reserve a buffer slot for every in-flight ROM read so returned data always lands.
    assign issue = (state == S_SCAN) &&
                   ((buf_cnt + CW'(inflight)) < (CW'(BUF_DEPTH) + CW'(pop)));

    // done blocks start so a request coinciding with the done pulse is dropped
    assign start_accept = (state == S_IDLE) && start && !done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE:  if (start_accept) state_nxt = S_SCAN;
            S_SCAN:  if (issue && (issue_cnt == 6'd63)) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (pop && (emit_cnt == 6'd63)) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    // Next walker position for raster or zigzag order.
    always_comb begin
        row_nxt = row;
        col_nxt = col;
        if (!mode_q) begin
            if (col == 3'd7) begin
                col_nxt = 3'd0;
                row_nxt = row + 3'd1;
            end else begin
                col_nxt = col + 3'd1;
            end
        end else if ((row[0] ^ col[0]) == 1'b0) begin
            if (col == 3'd7) begin
                row_nxt = row + 3'd1;
            end else if (row == 3'd0) begin
                col_nxt = col + 3'd1;
            end else begin
                row_nxt = row - 3'd1;
                col_nxt = col + 3'd1;
            end
        end else begin
            if (row == 3'd7) begin
                col_nxt = col + 3'd1;
            end else if (col == 3'd0) begin
                row_nxt = row + 3'd1;
            end else begin
                row_nxt = row + 3'd1;
                col_nxt = col - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= 1'b0;
            row          <= 3'd0;
            col          <= 3'd0;
            issue_cnt    <= 6'd0;
            emit_cnt     <= 6'd0;
            inflight     <= 1'b0;
            inflight_idx <= 6'd0;
        end else if (start_accept) begin
            mode_q       <= mode;
            row          <= 3'd0;
            col          <= 3'd0;
            issue_cnt    <= 6'd0;
            emit_cnt     <= 6'd0;
            inflight     <= 1'b0;
            inflight_idx <= 6'd0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_idx <= issue_cnt;
                issue_cnt    <= issue_cnt + 6'd1;
                // the walker parks on the 64th address instead of wrapping
                if (issue_cnt != 6'd63) begin
                    row <= row_nxt;
                    col <= col_nxt;
                end
            end
            if (pop) emit_cnt <= emit_cnt + 6'd1;
        end
    end

    // Shift-register FIFO: entry 0 is always the head shown on out_*.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            data_nxt[i] = buf_data[i];
            idx_nxt[i]  = buf_idx[i];
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                data_nxt[i] = buf_data[i+1];
                idx_nxt[i]  = buf_idx[i+1];
            end
        end
        wr_ptr = buf_cnt - CW'(pop);
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ptr == CW'(i)) begin
                    data_nxt[i] = rom_d;
                    idx_nxt[i]  = inflight_idx;
                end
            end
        end
        cnt_nxt = buf_cnt + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_idx[i]  <= 6'd0;
            end
            buf_cnt   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_data[i] <= data_nxt[i];
                buf_idx[i]  <= idx_nxt[i];
            end
            buf_cnt   <= cnt_nxt;
            out_valid <= (cnt_nxt != '0);
            out_last  <= (cnt_nxt != '0) && (idx_nxt[0] == 6'd63);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (buf_cnt == CW'(BUF_DEPTH))));

endmodule

// File: tb/tb_rom_scan_sequencer.sv
// Scoreboard bench for rom_scan_sequencer: expected beats are queued at start,
// a negedge monitor pops and compares every transfer and checks stall stability.
module tb_rom_scan_sequencer;

    localparam int unsigned DW = 8;
    localparam int unsigned BD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic          busy;
    logic          done;
    logic [5:0]    rom_a;
    logic [DW-1:0] rom_d = '0;
    logic [DW-1:0] out_data;
    logic [5:0]    out_index;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;

    rom_scan_sequencer #(.DW(DW), .BUF_DEPTH(BD)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .rom_a     (rom_a),
        .rom_d     (rom_d),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [5:0] i;
        logic       l;
    } exp_t;

    exp_t       q[$];
    exp_t       e_mon;
    logic [7:0] rom_mem [64];
    int         zz [64] = '{ 0,  1,  8, 16,  9,  2,  3, 10,
                            17, 24, 32, 25, 18, 11,  4,  5,
                            12, 19, 26, 33, 40, 48, 41, 34,
                            27, 20, 13,  6,  7, 14, 21, 28,
                            35, 42, 49, 56, 57, 50, 43, 36,
                            29, 22, 15, 23, 30, 37, 44, 51,
                            58, 59, 52, 45, 38, 31, 39, 46,
                            53, 60, 61, 54, 47, 55, 62, 63};

    int         checks = 0;
    int         errors = 0;
    int         beats  = 0;
    logic       have_hold = 1'b0;
    logic [7:0] hold_d;
    logic [5:0] hold_i;

    initial begin
        for (int i = 0; i < 64; i++) rom_mem[i] = 8'(i * 29 + 7);
        rom_mem[0]  = 8'hFF;
        rom_mem[1]  = 8'h80;
        rom_mem[2]  = 8'h6C;
        rom_mem[7]  = 8'h3C;
        rom_mem[8]  = 8'h80;
        rom_mem[9]  = 8'h80;
        rom_mem[16] = 8'h6C;
        rom_mem[63] = 8'h19;
    end

    // Registered ROM with one clock of read latency.
    always @(posedge clk) rom_d <= rom_mem[rom_a];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            have_hold = 1'b0;
        end else begin
            if (have_hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(hold_d));
                chk("hold_index", 32'(out_index), 32'(hold_i));
                chk("buf_over_depth", 32'(dut.buf_cnt > 3'(BD)), 32'd0);
            end
            if (out_valid && out_ready) begin
                beats++;
                have_hold = 1'b0;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got index %0d data 0x%0h, expected no beat", out_index, out_data);
                end else begin
                    e_mon = q.pop_front();
                    chk("beat_data", 32'(out_data), 32'(e_mon.d));
                    chk("beat_index", 32'(out_index), 32'(e_mon.i));
                    chk("beat_last", 32'(out_last), 32'(e_mon.l));
                end
            end else if (out_valid) begin
                have_hold = 1'b1;
                hold_d    = out_data;
                hold_i    = out_index;
            end else begin
                have_hold = 1'b0;
            end
        end
    end

    task automatic push_exp(input logic m);
        int a;
        for (int i = 0; i < 64; i++) begin
            a = m ? zz[i] : i;
            q.push_back('{d: rom_mem[a], i: 6'(i), l: (i == 63)});
        end
    endtask

    // Returns just after the edge that samples start.
    task automatic start_scan(input logic m);
        @(posedge clk); #1;
        mode  = m;
        start = 1'b1;
        beats = 0;
        push_exp(m);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, input bit rnd);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < max) begin
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done) seen = 1'b1;
            n++;
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("busy_in_done_cycle", 32'(busy), 32'd0);
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("busy_after_done", 32'(busy), 32'd0);
        end
        out_ready = 1'b1;
    endtask

    task automatic scan_complete(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_queue_left"}, 32'(q.size()), 32'd0);
        chk({tag, "_beats"}, 32'(beats), 32'd64);
    endtask

    initial begin
        bit seen;
        int n;
        rst = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        chk("rst_rom_a", 32'(rom_a), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // raster, ready held high, with first-beat latency
        start_scan(1'b0);
        @(negedge clk);
        chk("lat_busy_e0", 32'(busy), 32'd1);
        chk("lat_valid_e0", 32'(out_valid), 32'd0);
        chk("lat_rom_a_e0", 32'(rom_a), 32'd0);
        @(negedge clk);
        chk("lat_valid_e1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid_e2", 32'(out_valid), 32'd1);
        chk("lat_data_e2", 32'(out_data), 32'hFF);
        wait_done(200, 1'b0);
        scan_complete("raster");

        // zigzag, ready held high
        start_scan(1'b1);
        wait_done(200, 1'b0);
        scan_complete("zigzag");

        // zigzag, random backpressure, mode toggled mid-scan
        start_scan(1'b1);
        mode = 1'b0;
        wait_done(1000, 1'b1);
        scan_complete("zigzag_rand");

        // ready low for 20 cycles after start
        out_ready = 1'b0;
        start_scan(1'b0);
        repeat (20) @(negedge clk);
        chk("stall_rom_a", 32'(rom_a), 32'd2);
        chk("stall_buf_cnt", 32'(dut.buf_cnt), 32'(BD));
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_index", 32'(out_index), 32'd0);
        chk("stall_data", 32'(out_data), 32'hFF);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done(300, 1'b0);
        scan_complete("stall");

        // reset mid-scan around beat 30, then a fresh scan
        start_scan(1'b0);
        n = 0;
        while (beats < 30 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midrst_reached_beat30", 32'(beats >= 30), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_last", 32'(out_last), 32'd0);
        chk("midrst_data", 32'(out_data), 32'd0);
        chk("midrst_index", 32'(out_index), 32'd0);
        chk("midrst_rom_a", 32'(rom_a), 32'd0);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        start_scan(1'b0);
        wait_done(200, 1'b0);
        scan_complete("after_rst");

        // start pulses while busy and in the done cycle are ignored
        start_scan(1'b1);
        repeat (3) begin
            repeat (7) @(posedge clk);
            #1 start = 1'b1; mode = 1'b0;
            @(posedge clk); #1 start = 1'b0;
        end
        seen = 1'b0;
        n = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            n++;
        end
        chk("ign_done_seen", 32'(seen), 32'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(negedge clk);
        chk("ign_busy_idle", 32'(busy), 32'd0);
        chk("ign_valid_idle", 32'(out_valid), 32'd0);
        scan_complete("ignore_start");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
